// File: rtl/rx_hex_display_buffer.sv
// Four-digit hex entry buffer: turns received ASCII bytes into seven-segment
// patterns, a 16-bit value, a digit count and a sticky error flag.
module rx_hex_display_buffer #(
    parameter bit         SCROLL    = 1'b1,
    parameter logic [6:0] BLANK_PAT = 7'h7F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [6:0]  dis_a,
    output logic [6:0]  dis_b,
    output logic [6:0]  dis_c,
    output logic [6:0]  dis_d,
    output logic [15:0] value,
    output logic [2:0]  digits,
    output logic        full,
    output logic        err
);

    typedef enum logic [1:0] {EMPTY, ENTRY, FULL} state_t;
    typedef enum logic [1:0] {C_INV, C_HEX, C_BS, C_CLR} cls_t;

    state_t state;

    function automatic cls_t classify(input logic [7:0] b);
        cls_t c;
        c = C_INV;
        if ((b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) ||
            (b >= 8'h61 && b <= 8'h66))
            c = C_HEX;
        else if (b == 8'h08 || b == 8'h7F)
            c = C_BS;
        else if (b == 8'h0D || b == 8'h1B)
            c = C_CLR;
        return c;
    endfunction

    // Letters of either case carry 1..6 in the low nibble, so +9 gives A..F.
    function automatic logic [3:0] to_nib(input logic [7:0] b);
        logic [3:0] n;
        if (b <= 8'h39)
            n = b[3:0];
        else
            n = b[3:0] + 4'd9;
        return n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h40;
            4'h1: p = 7'h79;
            4'h2: p = 7'h24;
            4'h3: p = 7'h30;
            4'h4: p = 7'h19;
            4'h5: p = 7'h12;
            4'h6: p = 7'h02;
            4'h7: p = 7'h78;
            4'h8: p = 7'h00;
            4'h9: p = 7'h10;
            4'hA: p = 7'h08;
            4'hB: p = 7'h03;
            4'hC: p = 7'h46;
            4'hD: p = 7'h21;
            4'hE: p = 7'h06;
            default: p = 7'h0E;
        endcase
        return p;
    endfunction

    cls_t       cls;
    logic [3:0] nib;

    assign cls = classify(rx_data);
    assign nib = to_nib(rx_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            dis_a  <= BLANK_PAT;
            dis_b  <= BLANK_PAT;
            dis_c  <= BLANK_PAT;
            dis_d  <= BLANK_PAT;
            value  <= 16'h0000;
            digits <= 3'd0;
            full   <= 1'b0;
            err    <= 1'b0;
        end else if (rx_valid) begin
            case (cls)
                C_HEX: begin
                    if (state != FULL || SCROLL) begin
                        value <= {value[11:0], nib};
                        dis_a <= dis_b;
                        dis_b <= dis_c;
                        dis_c <= dis_d;
                        dis_d <= enc(nib);
                    end else begin
                        err <= 1'b1;
                    end
                    // Scrolling in FULL keeps the count at four.
                    if (state != FULL) begin
                        digits <= digits + 3'd1;
                        full   <= (digits == 3'd3);
                        state  <= (digits == 3'd3) ? FULL : ENTRY;
                    end
                end
                C_BS: begin
                    if (state != EMPTY) begin
                        value  <= {4'h0, value[15:4]};
                        dis_a  <= BLANK_PAT;
                        dis_b  <= dis_a;
                        dis_c  <= dis_b;
                        dis_d  <= dis_c;
                        digits <= digits - 3'd1;
                        full   <= 1'b0;
                        state  <= (digits == 3'd1) ? EMPTY : ENTRY;
                    end
                end
                C_CLR: begin
                    state  <= EMPTY;
                    dis_a  <= BLANK_PAT;
                    dis_b  <= BLANK_PAT;
                    dis_c  <= BLANK_PAT;
                    dis_d  <= BLANK_PAT;
                    value  <= 16'h0000;
                    digits <= 3'd0;
                    full   <= 1'b0;
                    err    <= 1'b0;
                end
                default: begin
                    err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_hex_display_buffer.sv
// Directed bench for rx_hex_display_buffer; a scrolling and a non-scrolling
// instance share one stimulus stream.
module tb_rx_hex_display_buffer;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic [6:0]  dis_a, dis_b, dis_c, dis_d;
    logic [15:0] value;
    logic [2:0]  digits;
    logic        full, err;

    logic [6:0]  dis_a0, dis_b0, dis_c0, dis_d0;
    logic [15:0] value0;
    logic [2:0]  digits0;
    logic        full0, err0;

    int checks;
    int errors;

    rx_hex_display_buffer #(.SCROLL(1'b1), .BLANK_PAT(7'h7F)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .dis_a(dis_a), .dis_b(dis_b), .dis_c(dis_c), .dis_d(dis_d),
        .value(value), .digits(digits), .full(full), .err(err)
    );

    rx_hex_display_buffer #(.SCROLL(1'b0), .BLANK_PAT(7'h7F)) dut0 (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .dis_a(dis_a0), .dis_b(dis_b0), .dis_c(dis_c0), .dis_d(dis_d0),
        .value(value0), .digits(digits0), .full(full0), .err(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; call with the bench at a falling edge.
    task automatic put(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic check_disp(input string tag, input logic [6:0] a, input logic [6:0] b,
                              input logic [6:0] c, input logic [6:0] d);
        check({tag, ".dis_a"}, dis_a, a);
        check({tag, ".dis_b"}, dis_b, b);
        check({tag, ".dis_c"}, dis_c, c);
        check({tag, ".dis_d"}, dis_d, d);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset for three cycles with strobes that must be discarded
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_data  = 8'h35;
            rx_valid = (i != 1);
            @(negedge clk);
        end
        rst      = 1'b0;
        rx_valid = 1'b0;
        check_disp("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("reset.value", value, 16'h0000);
        check("reset.digits", digits, 3'd0);
        check("reset.full", full, 1'b0);
        check("reset.err", err, 1'b0);

        // Back-to-back entry of 1 2 a F
        rx_data = 8'h31; rx_valid = 1'b1; @(negedge clk);
        rx_data = 8'h32; @(negedge clk);
        rx_data = 8'h61; @(negedge clk);
        rx_data = 8'h46; @(negedge clk);
        rx_valid = 1'b0;
        check("fill.value", value, 16'h12AF);
        check("fill.digits", digits, 3'd4);
        check("fill.full", full, 1'b1);
        check_disp("fill", 7'h79, 7'h24, 7'h08, 7'h0E);
        check("fill.value0", value0, 16'h12AF);
        check("fill.full0", full0, 1'b1);

        // Hex on a full buffer: scroll vs reject
        put(8'h37);
        check("scroll.value", value, 16'h2AF7);
        check("scroll.dis_d", dis_d, 7'h78);
        check("scroll.dis_a", dis_a, 7'h24);
        check("scroll.err", err, 1'b0);
        check("scroll.digits", digits, 3'd4);
        check("noscroll.value0", value0, 16'h12AF);
        check("noscroll.dis_d0", dis_d0, 7'h0E);
        check("noscroll.err0", err0, 1'b1);

        // Clear and re-enter 12AF, then backspace
        put(8'h0D);
        check("clr1.err0", err0, 1'b0);
        put(8'h31); put(8'h32); put(8'h61); put(8'h46);
        put(8'h08); put(8'h08);
        check("bs2.value", value, 16'h0012);
        check("bs2.digits", digits, 3'd2);
        check("bs2.full", full, 1'b0);
        check_disp("bs2", 7'h7F, 7'h7F, 7'h79, 7'h24);
        put(8'h08); put(8'h7F); put(8'h08);
        check("bs5.digits", digits, 3'd0);
        check("bs5.value", value, 16'h0000);
        check_disp("bs5", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("bs5.err", err, 1'b0);

        // Invalid byte then CR
        put(8'h31); put(8'h32);
        put(8'h47);
        check("inv.value", value, 16'h0012);
        check("inv.digits", digits, 3'd2);
        check_disp("inv", 7'h7F, 7'h7F, 7'h79, 7'h24);
        check("inv.err", err, 1'b1);
        put(8'h0D);
        check_disp("cr", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
        check("cr.value", value, 16'h0000);
        check("cr.digits", digits, 3'd0);
        check("cr.err", err, 1'b0);

        // Entered zeros are shown, not blanked
        put(8'h30); put(8'h30);
        check("zero.digits", digits, 3'd2);
        check_disp("zero", 7'h7F, 7'h7F, 7'h40, 7'h40);
        put(8'h20);
        check("zero.err", err, 1'b1);

        // Reset wins over a simultaneous strobe
        rst = 1'b1; rx_data = 8'h35; rx_valid = 1'b1;
        @(negedge clk);
        rst = 1'b0; rx_valid = 1'b0;
        check("rst.digits", digits, 3'd0);
        check("rst.value", value, 16'h0000);
        check("rst.err", err, 1'b0);
        check("rst.dis_d", dis_d, 7'h7F);

        // Lowercase c, DEL as backspace, ESC as clear
        put(8'h63);
        check("lc.value", value, 16'h000C);
        check("lc.dis_d", dis_d, 7'h46);
        check("lc.digits", digits, 3'd1);
        put(8'h7F);
        check("del.digits", digits, 3'd0);
        check("del.dis_d", dis_d, 7'h7F);
        put(8'h67);
        check("g.err", err, 1'b1);
        put(8'h1B);
        check("esc.err", err, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_hex_display_buffer.md
Name: rx_hex_display_buffer

Overview:
- Sits between the UART receiver and the four-digit seven-segment multiplexer on the Rx board.
- Consumes received bytes as ASCII commands: hex characters are shifted in from the right, backspace deletes, and CR/ESC clears.
- Drives four 7-bit active-low segment patterns, leftmost digit first, ready to be wired straight into the multiplexer's digit inputs.
- Also exports the entered 16-bit value, the digit count and a sticky error flag.

Parameters:
- SCROLL, 1: behaviour when full. 1 = a new hex char drops the leftmost digit and shifts in. 0 = the char is rejected and err is set.
- BLANK_PAT, 7'h7F: pattern driven on unused (blank) positions.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte from the UART receiver
- rx_valid  in  1  single-cycle strobe; rx_data is valid in that cycle
- dis_a  out  7  leftmost digit pattern, active low, bit0=a … bit6=g
- dis_b  out  7  second digit pattern
- dis_c  out  7  third digit pattern
- dis_d  out  7  rightmost digit pattern (newest entry)
- value  out  16  entered nibbles; nibble3=dis_a … nibble0=dis_d; blank positions read 0
- digits  out  3  number of entered digits, 0..4
- full  out  1  digits==4
- err  out  1  sticky error flag

Behaviour:
- All outputs are registered. Reset state: dis_a..dis_d=BLANK_PAT, value=0, digits=0, full=0, err=0, state=EMPTY.
- rst has priority over rx_valid. A strobe in a reset cycle is discarded.
- Latency: outputs reflect a byte on the clk edge that samples rx_valid=1. Bytes arriving on consecutive cycles are each processed; there is no backpressure.
- Byte classes (anything outside these is INVALID):
  - HEX: 0x30-0x39, 0x41-0x46, 0x61-0x66. Lowercase maps to 0xA-0xF.
  - BS: 0x08 or 0x7F.
  - CLR: 0x0D or 0x1B.
- FSM with three states: EMPTY (digits=0), ENTRY (1..3), FULL (4).
- HEX in EMPTY or ENTRY:
  - value <= {value[11:0], nib}.
  - Patterns shift left, so dis_a<=dis_b, dis_b<=dis_c, dis_c<=dis_d, dis_d<=enc(nib).
  - digits increments; state moves EMPTY->ENTRY or ENTRY->FULL at 4.
- HEX in FULL:
  - SCROLL=1: same shift as above, digits stays 4, err unchanged.
  - SCROLL=0: no change to display or value; err<=1.
- BS in ENTRY or FULL:
  - value <= {4'h0, value[15:4]}.
  - Patterns shift right: dis_a<=BLANK_PAT, dis_b<=dis_a, and so on.
  - digits decrements; state moves FULL->ENTRY or ENTRY->EMPTY at 0.
- BS in EMPTY: ignored, err unchanged.
- CLR in any state: same as reset values, including err<=0.
- INVALID: display, value and digits unchanged; err<=1.
- err is cleared only by CLR or rst.
- Leading positions beyond digits are always BLANK_PAT. A leading zero digit that was actually entered is displayed, not blanked.
- enc (active low, bit0=a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Invariants:
  - full == (digits==4).
  - digits never exceeds 4 and never underflows.
  - The display patterns always equal the encoding of the corresponding value nibbles, for positions less than digits from the right.

Test Plan:
- Reset held 3 cycles while rx_valid pulses 0x35 -> dis_a..d=7F, value=0000, digits=0, err=0.
- Bytes '1','2','a','F' (0x31,0x32,0x61,0x46) on consecutive cycles -> value=12AF, digits=4, full=1, dis_a..d=79,24,08,0E.
- SCROLL=1, after the previous step send '7' -> value=2AF7, dis_d=78, dis_a=24, err=0. SCROLL=0 build, same stimulus -> value=12AF unchanged, err=1.
- From value 12AF send BS,BS -> value=0012, digits=2, dis_a..d=7F,7F,79,24. Further BS x3 -> digits=0, all 7F, err=0.
- Send 0x47 ('G') from value 0012 -> display unchanged, err=1. Then 0x0D -> all blank, value=0, err=0.
- Send '0','0' -> digits=2, dis_c=dis_d=40 (entered zeros displayed). rst pulsed mid-sequence with rx_valid=1 -> reset values next cycle.
